// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single registered-read RAM. Sticky round-robin:
// the last granted port keeps the RAM until it stops requesting or has taken
// MAX_BURST consecutive grants while the other port was waiting.
module ram_port_arbiter #(
    parameter int unsigned ADDR      = 14,
    parameter int unsigned DATA      = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    // Port A
    input  logic            a_req,
    input  logic            a_we,
    input  logic [ADDR-1:0] a_addr,
    input  logic [DATA-1:0] a_wdata,
    output logic            a_gnt,
    output logic            a_rvalid,
    output logic [DATA-1:0] a_rdata,
    // Port B
    input  logic            b_req,
    input  logic            b_we,
    input  logic [ADDR-1:0] b_addr,
    input  logic [DATA-1:0] b_wdata,
    output logic            b_gnt,
    output logic            b_rvalid,
    output logic [DATA-1:0] b_rdata,
    // RAM side
    output logic            ram_wr_en,
    output logic            ram_rd_en,
    output logic [ADDR-1:0] ram_wr_addr,
    output logic [ADDR-1:0] ram_rd_addr,
    output logic [DATA-1:0] ram_wr_data,
    input  logic [DATA-1:0] ram_rd_data
);

    localparam int unsigned     CNTW   = $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] CntMax = CNTW'(MAX_BURST);

    typedef enum logic [0:0] {StOwnA, StOwnB} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            rd_tag_a_q, rd_tag_b_q;
    logic            cap;
    logic            owner_gnt;

    // Owner has used up its burst allowance
    assign cap = (cnt_q >= CntMax);

    // Grant decision plus owner / burst-counter next state; all grants masked in reset
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        owner_gnt = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (rst_n) begin
            unique case (state_q)
                StOwnA: begin
                    if (a_req && !(b_req && cap)) begin
                        a_gnt     = 1'b1;
                        owner_gnt = 1'b1;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                    end
                end
                StOwnB: begin
                    if (b_req && !(a_req && cap)) begin
                        b_gnt     = 1'b1;
                        owner_gnt = 1'b1;
                    end else if (a_req) begin
                        a_gnt = 1'b1;
                    end
                end
                default: ;
            endcase

            if (owner_gnt) begin
                cnt_d = cap ? cnt_q : cnt_q + CNTW'(1);
            end else if (a_gnt || b_gnt) begin
                state_d = a_gnt ? StOwnA : StOwnB;
                cnt_d   = CNTW'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Owner, burst count and read-return tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StOwnA;
            cnt_q      <= '0;
            rd_tag_a_q <= 1'b0;
            rd_tag_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_tag_a_q <= a_gnt && !a_we;
            rd_tag_b_q <= b_gnt && !b_we;
        end
    end

    // Drive the granted port's operation straight onto the RAM this cycle
    always_comb begin
        ram_wr_en   = (a_gnt && a_we) || (b_gnt && b_we);
        ram_rd_en   = (a_gnt && !a_we) || (b_gnt && !b_we);
        ram_wr_addr = b_gnt ? b_addr : a_addr;
        ram_rd_addr = b_gnt ? b_addr : a_addr;
        ram_wr_data = b_gnt ? b_wdata : a_wdata;
    end

    // Read return: tag from last cycle steers rvalid; a read in flight across reset is dropped
    always_comb begin
        a_rvalid = rd_tag_a_q && rst_n;
        b_rvalid = rd_tag_b_q && rst_n;
        a_rdata  = ram_rd_data;
        b_rdata  = ram_rd_data;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: registered-read RAM model, a reference memory and
// per-port scoreboards of expected read returns checked by a separate monitor.
module tb_ram_port_arbiter;

    localparam int unsigned ADDR = 14;
    localparam int unsigned DATA = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_req, a_we, a_gnt, a_rvalid;
    logic [ADDR-1:0] a_addr;
    logic [DATA-1:0] a_wdata, a_rdata;
    logic            b_req, b_we, b_gnt, b_rvalid;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_wdata, b_rdata;
    logic            ram_wr_en, ram_rd_en;
    logic [ADDR-1:0] ram_wr_addr, ram_rd_addr;
    logic [DATA-1:0] ram_wr_data, ram_rd_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [DATA-1:0] data;
        int              due;
    } exp_t;

    exp_t            qa[$];
    exp_t            qb[$];
    logic [DATA-1:0] ref_mem[int];
    logic [DATA-1:0] mem[0:(1<<ADDR)-1];

    ram_port_arbiter #(.ADDR(ADDR), .DATA(DATA), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write lands at the edge, read data registered one cycle later
    initial for (int i = 0; i < (1 << ADDR); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA-1:0] ref_rd(input logic [ADDR-1:0] addr);
        return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
    endfunction

    // Issue monitor: grant sanity, RAM strobe checks, reference writes, expectation pushes
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {a_gnt, b_gnt, ram_wr_en, ram_rd_en}, 4'b0);
        end else begin
            if (a_gnt && b_gnt) chk("double_gnt", {a_gnt, b_gnt}, 2'b10);
            if (a_gnt && !a_req) chk("a_gnt_no_req", a_gnt, 1'b0);
            if (b_gnt && !b_req) chk("b_gnt_no_req", b_gnt, 1'b0);
            chk("strobes", {ram_wr_en, ram_rd_en},
                {(a_gnt && a_we) || (b_gnt && b_we), (a_gnt && !a_we) || (b_gnt && !b_we)});
            if (a_gnt) begin
                if (a_we) begin
                    chk("a_wr_bus", {ram_wr_addr, ram_wr_data}, {a_addr, a_wdata});
                    ref_mem[int'(a_addr)] = a_wdata;
                end else begin
                    chk("a_rd_addr", ram_rd_addr, a_addr);
                    qa.push_back('{data: ref_rd(a_addr), due: cyc + 1});
                end
            end else if (b_gnt) begin
                if (b_we) begin
                    chk("b_wr_bus", {ram_wr_addr, ram_wr_data}, {b_addr, b_wdata});
                    ref_mem[int'(b_addr)] = b_wdata;
                end else begin
                    chk("b_rd_addr", ram_rd_addr, b_addr);
                    qb.push_back('{data: ref_rd(b_addr), due: cyc + 1});
                end
            end
        end
    end

    // Return monitor: pops expected reads exactly one cycle after issue
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_rvalid", {a_rvalid, b_rvalid}, 2'b0);
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                chk("a_rvalid", a_rvalid, 1'b1);
                chk("a_rdata", a_rdata, qa[0].data);
                void'(qa.pop_front());
            end else if (a_rvalid) begin
                chk("a_rvalid_spurious", a_rvalid, 1'b0);
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                chk("b_rvalid", b_rvalid, 1'b1);
                chk("b_rdata", b_rdata, qb[0].data);
                void'(qb.pop_front());
            end else if (b_rvalid) begin
                chk("b_rvalid_spurious", b_rvalid, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0;
        b_req = 1'b0;
        a_we  = 1'b0;
        b_we  = 1'b0;
    endtask

    initial begin
        // Reset with both ports requesting
        rst_n = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = 14'h0020; b_addr = 14'h0030; a_wdata = '0; b_wdata = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", {a_gnt, b_gnt, ram_wr_en, ram_rd_en}, 4'b0);
        end
        tick();
        rst_n = 1'b1;

        // Continuous contention: 16 A grants, 16 B grants, repeating
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("contention", {a_gnt, b_gnt}, ((i / 16) % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        idle();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single port write then read of same address
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0010; a_wdata = 32'h55AA00FF;
        @(negedge clk);
        chk("t2_wr_gnt", {a_gnt, ram_wr_en, ram_rd_en}, 3'b110);
        tick();
        a_we = 1'b0;
        @(negedge clk);
        chk("t2_rd_gnt", {a_gnt, ram_wr_en, ram_rd_en}, 3'b101);
        tick();
        idle();
        @(negedge clk);
        chk("t2_ret", {a_rvalid, b_rvalid, a_rdata}, {2'b10, 32'h55AA00FF});
        tick();

        // A bursts 3 reads, drops; B takes over with cnt=1, then keeps 15 more grants
        a_req = 1'b1; a_addr = 14'h0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_a_burst", {a_gnt, b_gnt}, 2'b10);
            tick();
        end
        a_req = 1'b0; b_req = 1'b1; b_addr = 14'h0010;
        @(negedge clk);
        chk("t4_handover", {a_gnt, b_gnt}, 2'b01);
        tick();
        a_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("t4_b_burst", {a_gnt, b_gnt}, 2'b01);
            tick();
        end
        @(negedge clk);
        chk("t4_cap_to_a", {a_gnt, b_gnt}, 2'b10);
        tick();
        idle();
        tick();

        // A writes top address, B reads it the very next cycle
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h3FFF; a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t5_a_wr", {a_gnt, b_gnt, ram_wr_en}, 3'b101);
        tick();
        a_req = 1'b0; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 14'h3FFF;
        @(negedge clk);
        chk("t5_b_rd", {a_gnt, b_gnt, ram_rd_en}, 3'b011);
        tick();
        idle();
        @(negedge clk);
        chk("t5_ret", {b_rvalid, a_rvalid, b_rdata}, {2'b10, 32'hDEADBEEF});
        tick();

        // Reset lands while an A read is in flight
        a_req = 1'b1; a_addr = 14'h0010;
        @(negedge clk);
        chk("t6_a_gnt", a_gnt, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_no_rvalid", a_rvalid, 1'b0);
            tick();
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_rst", {a_rvalid, a_gnt}, 2'b00);
        tick();
        a_req = 1'b1; a_addr = 14'h3FFF;
        @(negedge clk);
        chk("t6_restart_gnt", {a_gnt, b_gnt}, 2'b10);
        tick();
        idle();
        @(negedge clk);
        chk("t6_restart_ret", {a_rvalid, a_rdata}, {1'b1, 32'hDEADBEEF});
        repeat (3) tick();
        @(negedge clk);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
